// File: rtl/uart_pkg.sv
// Shared defaults and FSM state type for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 16;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side byte handshakes of the arbiter, bundled together.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;

    // Arbiter view.
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );

    // Requester / UART TX view.
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [IdxW-1:0]    winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic                 found;

    // Upper copy always survives the mask, so the lowest set bit gives the wrapped winner.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dbl[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (masked[i] && !found) begin
                found  = 1'b1;
                winner = IdxW'(i % NUM_REQ);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter feeding one UART TX through a registered byte stage.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned MAX_BURST = MAX_BURST_DEF,
    localparam int unsigned IdxW      = $clog2(NUM_REQ),
    localparam int unsigned CntW      = $clog2(MAX_BURST)
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_arbiter_if.slave    bus,
    output logic [IdxW-1:0]     grant_id,
    output logic                busy
);

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [CntW-1:0]   beat_q, beat_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic [IdxW-1:0]    winner;
    logic               any_req;
    logic               slot_free;
    logic               accept;
    logic               release_now;
    logic [NUM_REQ-1:0] req_ready;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    // Ready never looks at req_valid, so there is no valid->ready combinational path.
    always_comb begin
        slot_free   = !tx_valid_q || bus.tx_ready;
        req_ready   = '0;
        if (state_q == StLocked) begin
            req_ready[grant_q] = slot_free;
        end
        accept      = (state_q == StLocked) && bus.req_valid[grant_q] && slot_free;
        release_now = accept && (bus.req_last[grant_q] || (beat_q == CntW'(MAX_BURST - 1)));
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StLocked;
                    grant_d = winner;
                end
            end
            StLocked: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                end
                if (release_now) begin
                    state_d = StIdle;
                    beat_d  = '0;
                    ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pending byte drains in either state, so it survives a release.
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.req_data[grant_q*DATA_W +: DATA_W];
        end else if (bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            beat_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == StLocked);

endmodule
